// File: rtl/i2c_cfg_sequencer.sv
// Command-FIFO driven sequencer for the byte-serial register port of i2c_u_fpga:
// replays address-load, data-load and access-strobe phases with programmable timing.
module i2c_cfg_sequencer #(
   parameter int SETUP_CYC  = 6,
   parameter int STROBE_CYC = 6,
   parameter int GAP_CYC    = 11,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 8
) (
   input  logic       pclk,
   input  logic       prst,
   input  logic       seq_en,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rd,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic [7:0] data_in,
   output logic       data_sel,
   output logic       data_wr,
   output logic       apb_we,
   output logic       apb_re,
   input  logic [7:0] data_out,
   output logic       rsp_valid,
   output logic       rsp_rd,
   output logic [7:0] rsp_rdata,
   output logic       busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYC - 1);

   typedef enum logic [3:0] {
      IDLE,
      A_SET,
      A_STB,
      A_GAP,
      D_SET,
      D_STB,
      D_GAP,
      X_STB,
      X_GAP
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] timer;
   logic [16:0]      fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [16:0]      head;
   logic             push;
   logic             pop;
   logic             timer_done;
   logic             complete_next;
   logic             cur_rd;
   logic [7:0]       cur_wdata;
   logic [7:0]       rdata_cap;

   assign cmd_ready  = (count != FULL_CNT);
   assign push       = cmd_valid && cmd_ready;
   assign pop        = (state == IDLE) && (count != '0) && seq_en;
   assign head       = fifo_mem[rd_ptr];
   assign busy       = (state != IDLE) || (count != '0);
   assign timer_done = (timer == '0);

   // rsp_valid is registered, so it is raised one edge ahead of the last X_GAP cycle;
   // with a one-cycle gap that edge is the X_STB exit itself.
   assign complete_next = ((state == X_STB) && timer_done && (GAP_CYC == 1)) ||
                          ((state == X_GAP) && (timer == CNT_W'(1)));

   always_ff @(posedge pclk) begin
      if (push) fifo_mem[wr_ptr] <= {cmd_rd, cmd_addr, cmd_wdata};
   end

   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         state     <= IDLE;
         timer     <= '0;
         cur_rd    <= 1'b0;
         cur_wdata <= '0;
         rdata_cap <= '0;
         data_in   <= '0;
         data_sel  <= 1'b0;
         data_wr   <= 1'b0;
         apb_we    <= 1'b0;
         apb_re    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rd    <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= complete_next;
         if (complete_next) begin
            rsp_rd    <= cur_rd;
            rsp_rdata <= (state == X_STB) ? (cur_rd ? data_out : '0) : rdata_cap;
         end

         case (state)
            IDLE: begin
               if (pop) begin
                  cur_rd    <= head[16];
                  cur_wdata <= head[7:0];
                  data_in   <= head[15:8];
                  data_sel  <= 1'b0;
                  timer     <= SETUP_LD;
                  state     <= A_SET;
               end
            end
            A_SET: begin
               if (timer_done) begin
                  data_wr <= 1'b1;
                  timer   <= STROBE_LD;
                  state   <= A_STB;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            A_STB: begin
               if (timer_done) begin
                  data_wr <= 1'b0;
                  timer   <= GAP_LD;
                  state   <= A_GAP;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            A_GAP: begin
               if (timer_done) begin
                  if (cur_rd) begin
                     apb_re <= 1'b1;
                     timer  <= STROBE_LD;
                     state  <= X_STB;
                  end else begin
                     data_in  <= cur_wdata;
                     data_sel <= 1'b1;
                     timer    <= SETUP_LD;
                     state    <= D_SET;
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            D_SET: begin
               if (timer_done) begin
                  data_wr <= 1'b1;
                  timer   <= STROBE_LD;
                  state   <= D_STB;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            D_STB: begin
               if (timer_done) begin
                  data_wr <= 1'b0;
                  timer   <= GAP_LD;
                  state   <= D_GAP;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            D_GAP: begin
               if (timer_done) begin
                  apb_we <= 1'b1;
                  timer  <= STROBE_LD;
                  state  <= X_STB;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            X_STB: begin
               if (timer_done) begin
                  apb_we    <= 1'b0;
                  apb_re    <= 1'b0;
                  rdata_cap <= cur_rd ? data_out : '0;
                  timer     <= GAP_LD;
                  state     <= X_GAP;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            X_GAP: begin
               if (timer_done) begin
                  data_in  <= '0;
                  data_sel <= 1'b0;
                  state    <= IDLE;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               timer <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Self-checking bench for i2c_cfg_sequencer: table-driven single transactions,
// hand-written corner sequences, and random traffic against a phase-offset model.
module tb_i2c_cfg_sequencer;

   localparam int S     = 6;
   localparam int T     = 6;
   localparam int G     = 11;
   localparam int DEPTH = 4;
   localparam int A_END = S + T + G;

   logic       pclk = 1'b0;
   logic       prst = 1'b1;
   logic       seq_en = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_rd = 1'b0;
   logic [7:0] cmd_addr = 8'h00;
   logic [7:0] cmd_wdata = 8'h00;
   logic [7:0] data_in;
   logic       data_sel;
   logic       data_wr;
   logic       apb_we;
   logic       apb_re;
   logic [7:0] data_out = 8'h00;
   logic       rsp_valid;
   logic       rsp_rd;
   logic [7:0] rsp_rdata;
   logic       busy;

   i2c_cfg_sequencer #(
      .SETUP_CYC  (S),
      .STROBE_CYC (T),
      .GAP_CYC    (G),
      .FIFO_DEPTH (DEPTH),
      .CNT_W      (8)
   ) dut (
      .pclk      (pclk),
      .prst      (prst),
      .seq_en    (seq_en),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_rd    (cmd_rd),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .data_in   (data_in),
      .data_sel  (data_sel),
      .data_wr   (data_wr),
      .apb_we    (apb_we),
      .apb_re    (apb_re),
      .data_out  (data_out),
      .rsp_valid (rsp_valid),
      .rsp_rd    (rsp_rd),
      .rsp_rdata (rsp_rdata),
      .busy      (busy)
   );

   always #5 pclk = ~pclk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
   endtask

   task automatic cyc();
      @(posedge pclk);
      #1;
   endtask

   task automatic push(input logic rd, input logic [7:0] addr, input logic [7:0] wdata);
      cmd_valid = 1'b1;
      cmd_rd    = rd;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cyc();
      cmd_valid = 1'b0;
   endtask

   // The current sample is the pop cycle (t=1); returns cycles from pop to rsp_valid, or -1.
   task automatic wait_rsp(input int budget, output int lat);
      lat = -1;
      for (int t = 1; t <= budget; t++) begin
         if (rsp_valid) begin
            lat = t - 1;
            break;
         end
         cyc();
      end
   endtask

   function automatic logic [23:0] obs();
      return {data_in, data_sel, data_wr, apb_we, apb_re, rsp_valid, rsp_rd, rsp_rdata, busy, cmd_ready};
   endfunction

   // Reference model: each transaction is described by its offset k from the pop cycle.
   typedef struct packed {
      logic       rd;
      logic [7:0] addr;
      logic [7:0] wdata;
   } cmd_t;

   cmd_t       mq[$];
   bit         m_act;
   int         m_k;
   cmd_t       m_cur;
   logic       m_rrd;
   logic [7:0] m_rdata;
   logic [7:0] m_cap;

   function automatic int txn_len(input logic rd);
      return rd ? (S + T + G + T + G) : (2 * (S + T + G) + T + G);
   endfunction

   task automatic model_reset();
      mq.delete();
      m_act   = 0;
      m_k     = 0;
      m_cur   = '0;
      m_rrd   = 1'b0;
      m_rdata = 8'h00;
      m_cap   = 8'h00;
   endtask

   task automatic model_edge(input logic v, input logic se, input cmd_t c, input logic [7:0] dout);
      bit do_pop;
      bit do_push;
      int L;
      do_pop  = !m_act && (mq.size() > 0) && se;
      do_push = v && (mq.size() < DEPTH);
      if (m_act) begin
         L = txn_len(m_cur.rd);
         if (m_k == L - G) m_cap = m_cur.rd ? dout : 8'h00;
         m_k++;
         if (m_k == L) begin
            m_rrd   = m_cur.rd;
            m_rdata = m_cap;
         end
         if (m_k > L) m_act = 0;
      end
      if (do_pop) begin
         m_cur = mq.pop_front();
         m_act = 1;
         m_k   = 1;
      end
      if (do_push) mq.push_back(c);
   endtask

   function automatic logic [23:0] model_exp();
      int         L;
      int         xs;
      logic [7:0] din;
      logic       sel, wr, we, re, rv;
      din = 8'h00; sel = 1'b0; wr = 1'b0; we = 1'b0; re = 1'b0; rv = 1'b0;
      if (m_act) begin
         L   = txn_len(m_cur.rd);
         xs  = L - G - T;
         sel = !m_cur.rd && (m_k > A_END);
         din = sel ? m_cur.wdata : m_cur.addr;
         wr  = (m_k > S && m_k <= S + T) ||
               (!m_cur.rd && m_k > A_END + S && m_k <= A_END + S + T);
         we  = !m_cur.rd && m_k > xs && m_k <= xs + T;
         re  =  m_cur.rd && m_k > xs && m_k <= xs + T;
         rv  = (m_k == L);
      end
      return {din, sel, wr, we, re, rv, m_rrd, m_rdata, (m_act || mq.size() > 0), (mq.size() < DEPTH)};
   endfunction

   typedef struct {
      logic       rd;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] dout;
      int         lat;
      int         n_wr;
      int         n_we;
      int         n_re;
      int         n_acnt;
      int         n_dcnt;
      logic       exp_rd;
      logic [7:0] exp_rdata;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat, nwr, nwe, nre, na, nd, cnt, n, last_busy;
      logic       grd;
      logic [7:0] gdat;
      int         times[8];
      logic [8:0] rsps[8];
      logic [8:0] exp_order[4];
      cmd_t       c;

      vecs[0] = '{1'b0, 8'h1C, 8'h03, 8'h5A, 63, 12, 6, 0, 23, 40, 1'b0, 8'h00};
      vecs[1] = '{1'b1, 8'h2C, 8'h00, 8'hA5, 40,  6, 0, 6, 40,  0, 1'b1, 8'hA5};
      vecs[2] = '{1'b0, 8'hFF, 8'hFF, 8'h00, 63, 12, 6, 0, 23, 40, 1'b0, 8'h00};
      vecs[3] = '{1'b1, 8'h01, 8'h77, 8'h3C, 40,  6, 0, 6, 40,  0, 1'b1, 8'h3C};
      vecs[4] = '{1'b0, 8'h80, 8'h00, 8'hC3, 63, 12, 6, 0, 23, 40, 1'b0, 8'h00};
      model_reset();

      // Reset state, during and after reset
      repeat (3) @(posedge pclk);
      #1;
      chk("reset_outputs", obs(), 24'h000001);
      @(negedge pclk);
      prst = 1'b0;
      cyc();
      chk("reset_release_outputs", obs(), 24'h000001);

      // Table-driven single transactions on an idle block
      seq_en = 1'b1;
      foreach (vecs[i]) begin
         data_out = vecs[i].dout;
         push(vecs[i].rd, vecs[i].addr, vecs[i].wdata);
         nwr = 0; nwe = 0; nre = 0; na = 0; nd = 0; lat = -1; grd = 1'bx; gdat = 8'hxx;
         for (int t = 1; t < 200; t++) begin
            if (data_wr) nwr++;
            if (apb_we) nwe++;
            if (apb_re) nre++;
            if (!data_sel && data_in == vecs[i].addr) na++;
            if (data_sel && data_in == vecs[i].wdata) nd++;
            if (rsp_valid) begin
               lat = t - 1; grd = rsp_rd; gdat = rsp_rdata;
               break;
            end
            cyc();
         end
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("vec%0d_data_wr_cycles", i), nwr, vecs[i].n_wr);
         chk($sformatf("vec%0d_apb_we_cycles", i), nwe, vecs[i].n_we);
         chk($sformatf("vec%0d_apb_re_cycles", i), nre, vecs[i].n_re);
         chk($sformatf("vec%0d_addr_phase_cycles", i), na, vecs[i].n_acnt);
         chk($sformatf("vec%0d_data_phase_cycles", i), nd, vecs[i].n_dcnt);
         chk($sformatf("vec%0d_rsp", i), {grd, gdat}, {vecs[i].exp_rd, vecs[i].exp_rdata});
         cyc();
         chk($sformatf("vec%0d_idle_after", i), {rsp_valid, busy, data_in, data_sel}, 11'h0);
      end

      // Reset asserted during A_STB of a write, with a second command queued
      data_out = 8'h5C;
      push(1'b0, 8'h1C, 8'h03);
      push(1'b1, 8'h2C, 8'h00);
      for (int t = 0; t < 50 && !data_wr; t++) cyc();
      chk("rst_reach_astb", data_wr, 1'b1);
      cyc();
      cyc();
      #2 prst = 1'b1;
      #1 chk("rst_async_clear", obs(), 24'h000001);
      @(negedge pclk);
      prst = 1'b0;
      cnt = 0;
      for (int t = 0; t < 100; t++) begin
         cyc();
         if (rsp_valid) cnt++;
      end
      chk("rst_no_rsp", cnt, 0);
      push(1'b1, 8'h2C, 8'h00);
      wait_rsp(100, lat);
      chk("rst_then_read_latency", lat, 40);
      chk("rst_then_read_rsp", {rsp_rd, rsp_rdata}, {1'b1, 8'h5C});

      // seq_en dropped during D_STB with a read queued behind the write
      cyc();
      data_out = 8'h33;
      push(1'b0, 8'h2C, 8'h9E);
      push(1'b1, 8'h1C, 8'h00);
      for (int t = 0; t < 100 && !(data_sel && data_wr); t++) cyc();
      chk("den_reach_dstb", {data_sel, data_wr}, 2'b11);
      seq_en = 1'b0;
      wait_rsp(100, lat);
      chk("den_write_completes", {lat >= 0, rsp_rd, rsp_rdata}, {1'b1, 1'b0, 8'h00});
      cnt = 0;
      for (int t = 0; t < 100; t++) begin
         cyc();
         if (rsp_valid) cnt++;
      end
      chk("den_no_pop_while_disabled", cnt, 0);
      chk("den_queued_idle", {busy, data_sel, data_in}, {1'b1, 1'b0, 8'h00});
      seq_en = 1'b1;
      wait_rsp(100, lat);
      chk("den_resume_latency", lat, 40);
      chk("den_resume_rsp", {rsp_rd, rsp_rdata}, {1'b1, 8'h33});
      cyc();
      chk("den_busy_fall", busy, 1'b0);

      // Fill the FIFO with sequencing held off, then drop two extra pushes
      seq_en = 1'b0;
      data_out = 8'h77;
      push(1'b0, 8'h10, 8'h11);
      push(1'b1, 8'h20, 8'h00);
      push(1'b1, 8'h30, 8'h00);
      chk("full_ready_after_3", cmd_ready, 1'b1);
      push(1'b0, 8'h40, 8'h44);
      chk("full_ready_after_4", cmd_ready, 1'b0);
      push(1'b0, 8'h50, 8'h55);
      chk("full_push_dropped_ready", cmd_ready, 1'b0);
      seq_en = 1'b1;
      push(1'b0, 8'h60, 8'h66);
      chk("full_pop_with_push_ready", cmd_ready, 1'b1);
      n = 0;
      last_busy = -1;
      foreach (times[k]) begin
         times[k] = 0;
         rsps[k]  = '0;
      end
      for (int t = 0; t < 400; t++) begin
         if (rsp_valid && n < 8) begin
            times[n] = t;
            rsps[n]  = {rsp_rd, rsp_rdata};
            n++;
         end
         if (busy) last_busy = t;
         cyc();
      end
      exp_order[0] = {1'b0, 8'h00};
      exp_order[1] = {1'b1, 8'h77};
      exp_order[2] = {1'b1, 8'h77};
      exp_order[3] = {1'b0, 8'h00};
      chk("full_completion_count", n, 4);
      for (int k = 0; k < 4; k++) chk($sformatf("full_order_%0d", k), rsps[k], exp_order[k]);
      chk("full_gap_0_1", times[1] - times[0], 41);
      chk("full_gap_1_2", times[2] - times[1], 41);
      chk("full_gap_2_3", times[3] - times[2], 64);
      chk("full_busy_fall", last_busy, times[3]);

      // Random traffic against the reference model
      prst = 1'b1;
      cmd_valid = 1'b0;
      seq_en = 1'b1;
      cyc();
      model_reset();
      @(negedge pclk);
      prst = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (seq_en) begin
            if ($urandom_range(0, 99) < 2) seq_en = 1'b0;
         end else if ($urandom_range(0, 99) < 20) begin
            seq_en = 1'b1;
         end
         cmd_valid = ($urandom_range(0, 99) < 35);
         cmd_rd    = 1'($urandom_range(0, 1));
         cmd_addr  = 8'($urandom);
         cmd_wdata = 8'($urandom);
         data_out  = 8'($urandom);
         c.rd = cmd_rd;
         c.addr = cmd_addr;
         c.wdata = cmd_wdata;
         cyc();
         model_edge(cmd_valid, seq_en, c, data_out);
         chk($sformatf("rand_cycle_%0d", i), obs(), model_exp());
         chk($sformatf("rand_strobe_excl_%0d", i), ($countones({data_wr, apb_we, apb_re}) <= 1), 1'b1);
      end
      cmd_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/i2c_cfg_sequencer.md
Name: i2c_cfg_sequencer

Overview:
- Command-driven sequencer for the byte-serial register-access port of the i2c_u_fpga wrapper (data_in / data_sel / data_wr / apb_we / apb_re).
- Replaces hand-timed bench or CPU bit-banging of that port. A requester queues {rd/wr, addr, wdata} commands.
- The block replays the address-load, data-load and access-strobe phases with programmable cycle timing, then returns read data and a completion pulse.
- One instance drives either the master-side or the slave-side port set.

Parameters:
- SETUP_CYC, 6, cycles data_in/data_sel are stable before a data_wr strobe
- STROBE_CYC, 6, width in cycles of each data_wr / apb_we / apb_re pulse
- GAP_CYC, 11, idle cycles after each strobe
- FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2)
- CNT_W, 8, timer width; must hold max(SETUP_CYC, STROBE_CYC, GAP_CYC)

Ports:
- pclk  in  1  clock
- prst  in  1  asynchronous active-high reset
- seq_en  in  1  when 0, no new command is popped; the current transaction completes
- cmd_valid  in  1  command push request
- cmd_ready  out  1  FIFO not full; push occurs when cmd_valid & cmd_ready
- cmd_rd  in  1  1 = register read, 0 = register write
- cmd_addr  in  8  register address (e.g. 8'h1C control, 8'h2C data)
- cmd_wdata  in  8  write data; ignored for reads
- data_in  out  8  byte to the target loader
- data_sel  out  1  0 = address byte, 1 = data byte
- data_wr  out  1  loader strobe
- apb_we  out  1  register write access strobe
- apb_re  out  1  register read access strobe
- data_out  in  8  target read data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rd  out  1  type of the completed command
- rsp_rdata  out  8  captured read data; 8'h00 for writes
- busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Clock and reset: single clock pclk; reset prst is asynchronous and active-high.
- Reset: FIFO empty, FSM in IDLE, timer 0. All outputs 0 except cmd_ready = 1. Assertion of prst mid-transaction aborts it immediately with no completion pulse. Strobes drop asynchronously.
- FIFO:
  - cmd_ready = !full, computed from the registered count.
  - A push while full is ignored, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full keeps the count unchanged.
  - An entry pushed into an empty FIFO can be popped the following cycle at the earliest.
- Pop: in IDLE with FIFO non-empty and seq_en = 1, the head is popped into the command register. The FSM goes to A_SET the next cycle.
- FSM states and phase lengths (each timed state lasts exactly its parameter count, then advances):
  - A_SET (SETUP_CYC): data_in = addr, data_sel = 0
  - A_STB (STROBE_CYC): data_wr = 1
  - A_GAP (GAP_CYC): data_wr = 0
  - Write path: D_SET (SETUP_CYC): data_in = wdata, data_sel = 1 → D_STB (STROBE_CYC): data_wr = 1 → D_GAP (GAP_CYC) → X_STB
  - Read path: A_GAP → X_STB directly
  - X_STB (STROBE_CYC): apb_we = !rd, apb_re = rd
  - X_GAP (GAP_CYC) → IDLE
- Output holding: data_in and data_sel hold their values through the STB and GAP states that follow. They return to 0 only in IDLE.
- Read capture: rsp_rdata is registered from data_out on the last cycle of X_STB for reads.
- Completion: rsp_valid = 1 for exactly one cycle, on the last cycle of X_GAP. rsp_rd and rsp_rdata are valid in that cycle and hold until the next completion.
- Latency from pop cycle to rsp_valid, with defaults:
  - write: 1 + 63 - 1 = 63 cycles
  - read: 1 + 40 - 1 = 40 cycles
- Back-to-back commands: IDLE may pop in the cycle after X_GAP ends. Minimum 1 IDLE cycle between transactions.
- Strobe exclusivity: at most one of data_wr, apb_we, apb_re is high in any cycle.
- seq_en deasserted mid-transaction: the transaction completes normally; no further pops occur.
- Timer: an CNT_W-bit down-counter loaded with (param-1) on state entry. The state advances when the counter reaches 0. Parameters are never 0.

Test Plan:
- Write 0x1C/0x03 into an idle block → data_sel=0, data_in=1C for 6 cycles; data_wr high 6 cycles; 11 idle; data_sel=1, data_in=03; data_wr 6; gap 11; apb_we high 6 cycles; rsp_valid with rsp_rd=0 exactly 63 cycles after the pop.
- Read 0x2C with data_out=8'hA5 held → apb_we never asserted; apb_re high 6 cycles; rsp_rd=1, rsp_rdata=A5 on rsp_valid, 40 cycles after the pop.
- seq_en=0, push 4 commands → cmd_ready drops after the 4th; a 5th push is dropped. Then seq_en=1 → 4 completions in push order, 1 IDLE cycle between them; busy falls after the last.
- Push into a full FIFO in the same cycle as a pop → the push is rejected; the count goes from 4 to 3.
- prst asserted during A_STB of a write → data_wr and all outputs 0 immediately; FIFO empty; no rsp_valid. After release, a new read completes normally.
- seq_en dropped during D_STB → the current write finishes with rsp_valid; a queued command stays in the FIFO until seq_en returns to 1.
